cva6_obi_nto1_mux: RTL and testbench



---
 rtl/cva6_obi_nto1_mux.sv | 155 +++++++++++++++
 tb/tb_cva6_obi_nto1_mux.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_obi_nto1_mux.sv
// rtl/cva6_obi_nto1_mux.sv - N-to-1 OBI request mux with round-robin arbitration and response router.
// Optional CVA6_OBI_MUX_ID_ROUTE_EN: route responses by rid port bits with an outstanding counter.
module cva6_obi_nto1_mux #(
  parameter int NR_PORTS        = 4,
  parameter int ADDR_WIDTH      = 34,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDX_W          = $clog2(NR_PORTS),
  localparam int MID_W          = ID_WIDTH + IDX_W
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NR_PORTS-1:0]              up_req_i,
  output logic [NR_PORTS-1:0]              up_gnt_o,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0]   up_addr_i,
  input  logic [NR_PORTS-1:0]              up_we_i,
  input  logic [NR_PORTS*DATA_WIDTH/8-1:0] up_be_i,
  input  logic [NR_PORTS*DATA_WIDTH-1:0]   up_wdata_i,
  input  logic [NR_PORTS*ID_WIDTH-1:0]     up_aid_i,
  output logic [NR_PORTS-1:0]              up_rvalid_o,
  input  logic [NR_PORTS-1:0]              up_rready_i,
  output logic [DATA_WIDTH-1:0]            up_rdata_o,
  output logic [ID_WIDTH-1:0]              up_rid_o,
  output logic                             up_err_o,
  output logic                             dn_req_o,
  input  logic                             dn_gnt_i,
  output logic [ADDR_WIDTH-1:0]            dn_addr_o,
  output logic                             dn_we_o,
  output logic [DATA_WIDTH/8-1:0]          dn_be_o,
  output logic [DATA_WIDTH-1:0]            dn_wdata_o,
  output logic [MID_W-1:0]                 dn_aid_o,
  input  logic                             dn_rvalid_i,
  output logic                             dn_rready_o,
  input  logic [DATA_WIDTH-1:0]            dn_rdata_i,
  input  logic [MID_W-1:0]                 dn_rid_i,
  input  logic                             dn_err_i,
  output logic                             spurious_o
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int AW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [AW:0] MAX_CNT = (AW+1)'(MAX_OUTSTANDING);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] lock_idx_q;
  logic             lock_q;
  logic [IDX_W-1:0] rr_sel;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic [IDX_W-1:0] sel;
  logic             hs;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [IDX_W-1:0] head;
  logic             head_ok;

  // Round-robin search begins one past the most recently granted port.
  always_comb begin
    rr_sel = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= NR_PORTS; i++) begin
      cand = IDX_W'((int'(last_q) + i) % NR_PORTS);
      if (!found && up_req_i[cand]) begin
        rr_sel = cand;
        found  = 1'b1;
      end
    end
  end

  assign sel      = lock_q ? lock_idx_q : rr_sel;
  assign dn_req_o = lock_q ? up_req_i[lock_idx_q] : ((|up_req_i) & ~full);
  assign hs       = dn_req_o & dn_gnt_i;
  assign push     = hs & ~full;
  assign up_gnt_o = hs ? (NR_PORTS'(1) << sel) : '0;

  assign dn_addr_o  = up_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign dn_we_o    = up_we_i[sel];
  assign dn_be_o    = up_be_i[sel*BE_W +: BE_W];
  assign dn_wdata_o = up_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
  assign dn_aid_o   = {sel, up_aid_i[sel*ID_WIDTH +: ID_WIDTH]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      if (hs) last_q <= sel;
      // Hold the selection while the address phase waits for a grant.
      lock_q     <= dn_req_o & ~dn_gnt_i;
      lock_idx_q <= sel;
    end
  end

`ifdef CVA6_OBI_MUX_ID_ROUTE_EN
  logic [AW:0] cnt_q;

  assign head  = dn_rid_i[MID_W-1:ID_WIDTH];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == MAX_CNT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (push && !pop) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end
`else
  logic [IDX_W-1:0] mem_q [2**AW];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic [AW:0]      occ;
  logic             unused_rid_hi;

  // Pointers carry one extra bit so full and empty remain distinguishable.
  assign occ           = wr_q - rd_q;
  assign empty         = (occ == '0);
  assign full          = (occ == MAX_CNT);
  assign head          = mem_q[rd_q[AW-1:0]];
  assign unused_rid_hi = ^dn_rid_i[MID_W-1:ID_WIDTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q[AW-1:0]] <= sel;
  end
`endif

  // An out-of-range port index is drained rather than routed.
  assign head_ok     = (int'(head) < NR_PORTS);
  assign up_rvalid_o = (!empty && head_ok && dn_rvalid_i) ? (NR_PORTS'(1) << head) : '0;
  assign dn_rready_o = empty ? dn_rvalid_i : (head_ok ? up_rready_i[head] : 1'b1);
  assign pop         = dn_rvalid_i & dn_rready_o & ~empty;
  assign spurious_o  = dn_rvalid_i & empty;

  assign up_rdata_o = dn_rdata_i;
  assign up_rid_o   = dn_rid_i[ID_WIDTH-1:0];
  assign up_err_o   = dn_err_i;

endmodule

// File: tb/tb_cva6_obi_nto1_mux.sv
// tb/tb_cva6_obi_nto1_mux.sv - directed scoreboard bench for cva6_obi_nto1_mux.
module tb_cva6_obi_nto1_mux;

  localparam int NP = 4;
  localparam int AWD = 34;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int MO = 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [NP-1:0]    up_req_i = '0;
  logic [NP-1:0]    up_gnt_o;
  logic [NP*AWD-1:0] up_addr_i;
  logic [NP-1:0]    up_we_i;
  logic [NP*DW/8-1:0] up_be_i;
  logic [NP*DW-1:0] up_wdata_i;
  logic [NP*IW-1:0] up_aid_i;
  logic [NP-1:0]    up_rvalid_o;
  logic [NP-1:0]    up_rready_i = '0;
  logic [DW-1:0]    up_rdata_o;
  logic [IW-1:0]    up_rid_o;
  logic             up_err_o;
  logic             dn_req_o;
  logic             dn_gnt_i = 1'b0;
  logic [AWD-1:0]   dn_addr_o;
  logic             dn_we_o;
  logic [DW/8-1:0]  dn_be_o;
  logic [DW-1:0]    dn_wdata_o;
  logic [IW+1:0]    dn_aid_o;
  logic             dn_rvalid_i = 1'b0;
  logic             dn_rready_o;
  logic [DW-1:0]    dn_rdata_i = '0;
  logic [IW+1:0]    dn_rid_i = '0;
  logic             dn_err_i = 1'b0;
  logic             spurious_o;

  int errors = 0;
  int checks = 0;
  int sbq[$];
  int m_last = 0;
  bit m_lock = 0;
  int m_lock_idx = 0;

  cva6_obi_nto1_mux #(
    .NR_PORTS(NP), .ADDR_WIDTH(AWD), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .up_req_i(up_req_i), .up_gnt_o(up_gnt_o), .up_addr_i(up_addr_i), .up_we_i(up_we_i),
    .up_be_i(up_be_i), .up_wdata_i(up_wdata_i), .up_aid_i(up_aid_i),
    .up_rvalid_o(up_rvalid_o), .up_rready_i(up_rready_i), .up_rdata_o(up_rdata_o),
    .up_rid_o(up_rid_o), .up_err_o(up_err_o),
    .dn_req_o(dn_req_o), .dn_gnt_i(dn_gnt_i), .dn_addr_o(dn_addr_o), .dn_we_o(dn_we_o),
    .dn_be_o(dn_be_o), .dn_wdata_o(dn_wdata_o), .dn_aid_o(dn_aid_o),
    .dn_rvalid_i(dn_rvalid_i), .dn_rready_o(dn_rready_o), .dn_rdata_i(dn_rdata_i),
    .dn_rid_i(dn_rid_i), .dn_err_i(dn_err_i), .spurious_o(spurious_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [AWD-1:0] addr_of(input int p);
    return 34'h2_0000_0010 + AWD'(p) * 34'h1000;
  endfunction

  function automatic logic [IW-1:0] aid_of(input int p);
    return IW'(p * 3 + 1);
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int p);
    return 32'hA5A5_0000 + DW'(p);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, predict from the model, compare, then commit the model.
  task automatic cyc(input logic [3:0] req, input logic g, input logic rv,
                     input logic [3:0] rr, input int rid_sel);
    int sel, hm, cnt, c;
    bit fnd;
    logic exp_dreq, exp_rready, exp_spur;
    logic [3:0] exp_gnt, exp_rv;
    logic [DW-1:0] rd;
    logic [IW+1:0] rid;
    logic er;
    cnt = sbq.size();
    hm = (rid_sel >= 0) ? rid_sel : ((cnt > 0) ? sbq[0] : 0);
`ifndef CVA6_OBI_MUX_ID_ROUTE_EN
    hm = (cnt > 0) ? sbq[0] : 0;
`endif
    rd  = $urandom;
    rid = {2'(hm), 4'($urandom_range(0, 15))};
    er  = 1'($urandom_range(0, 1));
    up_req_i = req; dn_gnt_i = g; dn_rvalid_i = rv; up_rready_i = rr;
    dn_rdata_i = rd; dn_rid_i = rid; dn_err_i = er;
    sel = 0;
    fnd = 0;
    if (m_lock) sel = m_lock_idx;
    else begin
      for (int i = 1; i <= NP; i++) begin
        c = (m_last + i) % NP;
        if (!fnd && req[c]) begin sel = c; fnd = 1; end
      end
    end
    exp_dreq = m_lock ? req[m_lock_idx] : (req != 0 && cnt < MO);
    exp_gnt  = (exp_dreq && g) ? 4'(1 << sel) : 4'b0;
    if (cnt == 0) begin
      exp_rv = 4'b0; exp_rready = rv; exp_spur = rv;
    end else begin
      exp_rv = rv ? 4'(1 << hm) : 4'b0; exp_rready = rr[hm]; exp_spur = 1'b0;
    end
    #2;
    chk("dn_req", 64'(dn_req_o), 64'(exp_dreq));
    chk("up_gnt", 64'(up_gnt_o), 64'(exp_gnt));
    if (exp_dreq) begin
      chk("dn_addr", 64'(dn_addr_o), 64'(addr_of(sel)));
      chk("dn_aid", 64'(dn_aid_o), 64'({2'(sel), aid_of(sel)}));
      chk("dn_wdata", 64'(dn_wdata_o), 64'(wdata_of(sel)));
      chk("dn_we_be", 64'({dn_we_o, dn_be_o}), 64'({1'(sel % 2), 4'(1 << sel)}));
    end
    chk("up_rvalid", 64'(up_rvalid_o), 64'(exp_rv));
    chk("dn_rready", 64'(dn_rready_o), 64'(exp_rready));
    chk("spurious", 64'(spurious_o), 64'(exp_spur));
    if (rv) begin
      chk("up_rdata", 64'(up_rdata_o), 64'(rd));
      chk("up_rid", 64'(up_rid_o), 64'(rid[IW-1:0]));
      chk("up_err", 64'(up_err_o), 64'(er));
    end
    @(posedge clk_i);
    if (rv && exp_rready && cnt > 0) begin
`ifdef CVA6_OBI_MUX_ID_ROUTE_EN
      fnd = 0;
      for (int i = 0; i < sbq.size(); i++)
        if (!fnd && sbq[i] == hm) begin sbq.delete(i); fnd = 1; end
`else
      void'(sbq.pop_front());
`endif
    end
    if (exp_dreq && g) begin
      sbq.push_back(sel);
      m_last = sel;
    end
    m_lock = exp_dreq && !g;
    m_lock_idx = sel;
    #1;
  endtask

  task automatic reset_pulse();
    up_req_i = '0; dn_gnt_i = 0; dn_rvalid_i = 0; up_rready_i = '0;
    #1 rst_i = 1'b1;
    #1;
    chk("rst_dn_req", 64'(dn_req_o), 64'd0);
    chk("rst_up_gnt", 64'(up_gnt_o), 64'd0);
    chk("rst_up_rvalid", 64'(up_rvalid_o), 64'd0);
    chk("rst_dn_rready", 64'(dn_rready_o), 64'd0);
    chk("rst_spurious", 64'(spurious_o), 64'd0);
    #1 rst_i = 1'b0;
    sbq.delete();
    m_last = 0;
    m_lock = 0;
    m_lock_idx = 0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      up_addr_i[p*AWD +: AWD] = addr_of(p);
      up_we_i[p]              = 1'(p % 2);
      up_be_i[p*4 +: 4]       = 4'(1 << p);
      up_wdata_i[p*DW +: DW]  = wdata_of(p);
      up_aid_i[p*IW +: IW]    = aid_of(p);
    end
    @(posedge clk_i);
    #1;
    reset_pulse();
    cyc(4'b0000, 0, 0, 4'h0, -1);

    // Ports 0 and 2 alternate until the tracker fills; full blocks even with a pop.
    repeat (4) cyc(4'b0101, 1, 0, 4'hF, -1);
    cyc(4'b0101, 1, 0, 4'hF, -1);
    cyc(4'b0101, 1, 1, 4'hF, -1);
    cyc(4'b0101, 1, 0, 4'hF, -1);
    repeat (4) cyc(4'b0000, 0, 1, 4'hF, -1);

    // Address-phase lock: port 1 waits three cycles while port 0 joins.
    cyc(4'b0010, 0, 0, 4'hF, -1);
    cyc(4'b0011, 0, 0, 4'hF, -1);
    cyc(4'b0011, 0, 0, 4'hF, -1);
    cyc(4'b0011, 1, 0, 4'hF, -1);
    cyc(4'b0001, 1, 0, 4'hF, -1);
    repeat (2) cyc(4'b0000, 0, 1, 4'hF, -1);

    // In-order responses to ports 3 then 1 with port 3 stalling.
    cyc(4'b1000, 1, 0, 4'hF, -1);
    cyc(4'b0010, 1, 0, 4'hF, -1);
    repeat (2) cyc(4'b0000, 0, 1, 4'b0111, -1);
    repeat (2) cyc(4'b0000, 0, 1, 4'hF, -1);

    // Spurious response, simultaneous push and pop.
    cyc(4'b0000, 0, 1, 4'hF, -1);
    cyc(4'b0001, 1, 0, 4'hF, -1);
    cyc(4'b0010, 1, 1, 4'hF, -1);
    cyc(4'b0000, 0, 1, 4'hF, -1);

    // Reset with a transaction outstanding; its late response is spurious.
    cyc(4'b0100, 1, 0, 4'hF, -1);
    reset_pulse();
    cyc(4'b0000, 0, 1, 4'hF, -1);
    cyc(4'b0000, 0, 0, 4'h0, -1);

`ifdef CVA6_OBI_MUX_ID_ROUTE_EN
    cyc(4'b0001, 1, 0, 4'hF, -1);
    cyc(4'b0100, 1, 0, 4'hF, -1);
    cyc(4'b0000, 0, 1, 4'hF, 2);
    cyc(4'b0000, 0, 1, 4'hF, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
